// File: rtl/cordic_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// cordic_rr_scheduler_if
// Operand/result bus between the round-robin scheduler and one CORDIC
// rotation core.
//   Inp_The [AW] : rotation angle to the core
//   InpX/InpY [DW] : input vector to the core
//   Start_Pulse  : one-cycle start strobe to the core
//   OTPX/OTPY [DW] : rotated vector from the core
// master = scheduler side, slave = core side.
// -----------------------------------------------------------------------------
interface cordic_rr_scheduler_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic [AW-1:0] Inp_The;
    logic [DW-1:0] InpX;
    logic [DW-1:0] InpY;
    logic          Start_Pulse;
    logic [DW-1:0] OTPX;
    logic [DW-1:0] OTPY;

    modport master (
        output Inp_The, InpX, InpY, Start_Pulse,
        input  OTPX, OTPY
    );

    modport slave (
        input  Inp_The, InpX, InpY, Start_Pulse,
        output OTPX, OTPY
    );
endinterface

// File: rtl/cordic_rr_scheduler.sv
// -----------------------------------------------------------------------------
// cordic_rr_scheduler
// Shares one fixed-latency CORDIC core between two requesters. A request is
// granted (GNTn pulse, operands latched), the core is started with a one-cycle
// Start_Pulse, the scheduler waits LATENCY cycles, captures OTPX/OTPY into
// RES_X/RES_Y and pulses DONEn for the requester that owned the operation.
// Simultaneous requests alternate between requesters.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   REQn/THEn/Xn/Yn : requester n request and operands (n = 0,1)
//   GNTn            : one-cycle pulse, requester n operands captured
//   DONEn           : one-cycle pulse, RES_X/RES_Y hold requester n result
//   RES_X, RES_Y    : last captured core result
//   BUSY            : an operation is in flight
//   core            : operand/result bus to the CORDIC core (master side)
// All outputs are registered.
// -----------------------------------------------------------------------------
module cordic_rr_scheduler #(
    parameter int LATENCY = 9,   // Start_Pulse cycle to stable OTPX/OTPY, 1..255
    parameter int AW      = 9,
    parameter int DW      = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic [AW-1:0] THE0,
    input  logic [DW-1:0] X0,
    input  logic [DW-1:0] Y0,
    input  logic          REQ1,
    input  logic [AW-1:0] THE1,
    input  logic [DW-1:0] X1,
    input  logic [DW-1:0] Y1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          DONE0,
    output logic          DONE1,
    output logic [DW-1:0] RES_X,
    output logic [DW-1:0] RES_Y,
    output logic          BUSY,
    cordic_rr_scheduler_if.master core
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last, last_n;    // requester of the latest grant; also owner of the in-flight op
    logic          pick1;
    logic          gnt0_n, gnt1_n, done0_n, done1_n, start_n, busy_n;
    logic [DW-1:0] res_x_n, res_y_n, x_n, y_n;
    logic [AW-1:0] the_n;

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned; an unassigned path would infer a latch.
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        pick1   = 1'b0;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        done0_n = 1'b0;
        done1_n = 1'b0;
        start_n = 1'b0;
        res_x_n = RES_X;
        res_y_n = RES_Y;
        the_n   = core.Inp_The;
        x_n     = core.InpX;
        y_n     = core.InpY;

        unique case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    // Requester 1 wins when alone, or on a tie when 0 went last.
                    pick1   = REQ1 && (!REQ0 || !last);
                    last_n  = pick1;
                    the_n   = pick1 ? THE1 : THE0;
                    x_n     = pick1 ? X1   : X0;
                    y_n     = pick1 ? Y1   : Y0;
                    gnt0_n  = !pick1;
                    gnt1_n  = pick1;
                    state_n = START;
                end
            end
            START: begin
                start_n = 1'b1;
                cnt_n   = CW'(LATENCY);
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) state_n = CAPTURE;
            end
            CAPTURE: begin
                res_x_n = core.OTPX;
                res_y_n = core.OTPY;
                done0_n = !last;
                done1_n = last;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= IDLE;
            cnt              <= '0;
            last             <= 1'b1;
            GNT0             <= 1'b0;
            GNT1             <= 1'b0;
            DONE0            <= 1'b0;
            DONE1            <= 1'b0;
            RES_X            <= '0;
            RES_Y            <= '0;
            BUSY             <= 1'b0;
            core.Inp_The     <= '0;
            core.InpX        <= '0;
            core.InpY        <= '0;
            core.Start_Pulse <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            last             <= last_n;
            GNT0             <= gnt0_n;
            GNT1             <= gnt1_n;
            DONE0            <= done0_n;
            DONE1            <= done1_n;
            RES_X            <= res_x_n;
            RES_Y            <= res_y_n;
            BUSY             <= busy_n;
            core.Inp_The     <= the_n;
            core.InpX        <= x_n;
            core.InpY        <= y_n;
            core.Start_Pulse <= start_n;
        end
    end
endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cordic_rr_scheduler
// Drives cordic_rr_scheduler with directed scenarios and random requester
// traffic, with a CORDIC stub (OTPX = InpX ^ 8'hFF, OTPY = InpY + 1, valid
// LATENCY cycles after Start_Pulse). A transaction-level model predicts, from
// the grant cycle g, the cycles of GNT (g+1), Start_Pulse (g+2), BUSY
// (g+1..g+L+2) and DONE (g+L+3), plus operand and result values.
// -----------------------------------------------------------------------------
module tb_cordic_rr_scheduler;
    localparam int L  = 9;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] the0, the1;
    logic [DW-1:0] x0, y0, x1, y1;
    logic          gnt0, gnt1, done0, done1, busy;
    logic [DW-1:0] res_x, res_y;

    cordic_rr_scheduler_if #(.AW(AW), .DW(DW)) core_bus ();

    cordic_rr_scheduler #(.LATENCY(L), .AW(AW), .DW(DW)) dut (
        .CLK   (clk),
        .RST   (rst),
        .REQ0  (req0),
        .THE0  (the0),
        .X0    (x0),
        .Y0    (y0),
        .REQ1  (req1),
        .THE1  (the1),
        .X1    (x1),
        .Y1    (y1),
        .GNT0  (gnt0),
        .GNT1  (gnt1),
        .DONE0 (done0),
        .DONE1 (done1),
        .RES_X (res_x),
        .RES_Y (res_y),
        .BUSY  (busy),
        .core  (core_bus)
    );

    always #5 clk = ~clk;

    // CORDIC stub: outputs unknown after a start, valid L cycles after it.
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (core_bus.Start_Pulse) begin
            stub_cnt      <= L - 1;
            core_bus.OTPX <= 'x;
            core_bus.OTPY <= 'x;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_cnt == 1) begin
            stub_cnt      <= 0;
            core_bus.OTPX <= core_bus.InpX ^ 8'hFF;
            core_bus.OTPY <= core_bus.InpY + 8'd1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    int            free_at = 0;     // first cycle the scheduler is idle
    bit            active  = 1'b0;
    int            g       = 0;     // cycle in which the current op's request was sampled
    bit            gid     = 1'b0;
    bit            m_last  = 1'b1;
    logic [AW-1:0] m_the   = '0;
    logic [DW-1:0] m_x = '0, m_y = '0, m_rx = '0, m_ry = '0;

    // Observed event log
    int         gnt_cyc[2];
    int         done_cyc[2];
    int         done_n = 0;
    int         gnt_order[$];
    logic [7:0] done_rx[$];

    // One clock: the inputs currently driven are those sampled at the coming edge.
    task automatic step();
        bit            p_rst  = rst;
        bit            p_r0   = req0;
        bit            p_r1   = req1;
        logic [AW-1:0] p_the0 = the0, p_the1 = the1;
        logic [DW-1:0] p_x0 = x0, p_y0 = y0, p_x1 = x1, p_y1 = y1;
        int            p      = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (p_rst) begin
            active = 1'b0; m_last = 1'b1;
            m_the = '0; m_x = '0; m_y = '0; m_rx = '0; m_ry = '0;
            free_at = cyc;
        end else if (p >= free_at && (p_r0 || p_r1)) begin
            gid     = (p_r0 && p_r1) ? !m_last : p_r1;
            m_last  = gid;
            g       = p;
            active  = 1'b1;
            free_at = p + L + 3;
            m_the   = gid ? p_the1 : p_the0;
            m_x     = gid ? p_x1 : p_x0;
            m_y     = gid ? p_y1 : p_y0;
        end
        if (active && cyc == g + L + 3) begin
            m_rx = m_x ^ 8'hFF;
            m_ry = m_y + 8'd1;
        end
        check("gnt0",  32'(gnt0),  32'(active && cyc == g + 1 && !gid));
        check("gnt1",  32'(gnt1),  32'(active && cyc == g + 1 && gid));
        check("start", 32'(core_bus.Start_Pulse), 32'(active && cyc == g + 2));
        check("busy",  32'(busy),  32'(active && cyc >= g + 1 && cyc <= g + L + 2));
        check("done0", 32'(done0), 32'(active && cyc == g + L + 3 && !gid));
        check("done1", 32'(done1), 32'(active && cyc == g + L + 3 && gid));
        check("inp_the", 32'(core_bus.Inp_The), 32'(m_the));
        check("inp_x",   32'(core_bus.InpX),    32'(m_x));
        check("inp_y",   32'(core_bus.InpY),    32'(m_y));
        check("res_x",   32'(res_x), 32'(m_rx));
        check("res_y",   32'(res_y), 32'(m_ry));
        if (gnt0) begin gnt_cyc[0] = cyc; gnt_order.push_back(0); end
        if (gnt1) begin gnt_cyc[1] = cyc; gnt_order.push_back(1); end
        if (done0 || done1) begin
            if (done0) done_cyc[0] = cyc;
            if (done1) done_cyc[1] = cyc;
            done_n++;
            done_rx.push_back(res_x);
            check("res_known", 32'($isunknown({res_x, res_y})), 32'(0));
        end
    endtask

    task automatic drive_req(input bit seen, inout logic req, inout logic [AW-1:0] the,
                             inout logic [DW-1:0] x, inout logic [DW-1:0] y);
        if (req && seen) begin
            if ($urandom_range(0, 1) == 1) req = 1'b0;
            the = AW'($urandom_range(0, 511));
            x   = DW'($urandom);
            y   = DW'($urandom);
        end else if (!req && $urandom_range(0, 2) == 0) begin
            req = 1'b1;
            the = AW'($urandom_range(0, 511));
            x   = DW'($urandom);
            y   = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        gnt_order.delete();
        done_rx.delete();
    endtask

    initial begin
        int c0;
        int d;
        int g1[$];

        // Reset with REQ0 held, then a single request from requester 0.
        rst = 1'b1; req0 = 1'b1; the0 = 9'd511; x0 = 8'd64; y0 = 8'd0;
        req1 = 1'b0; the1 = '0; x1 = '0; y1 = '0;
        step();
        step();
        check("reset_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        c0 = cyc;
        gnt_cyc[0] = -1; done_cyc[0] = -1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (gnt0) req0 = 1'b0;
            if (cyc == c0 + 2) begin
                check("c2_start", 32'(core_bus.Start_Pulse), 32'(1));
                check("c2_the",   32'(core_bus.Inp_The), 32'(511));
                check("c2_x",     32'(core_bus.InpX), 32'(64));
                check("c2_y",     32'(core_bus.InpY), 32'(0));
            end
            if (cyc == c0 + 3) x0 = 8'd5;
        end
        check("single_gnt_cyc",  32'(gnt_cyc[0]),  32'(c0 + 1));
        check("single_done_cyc", 32'(done_cyc[0]), 32'(c0 + 12));
        check("single_res_x",    32'(res_x), 32'(8'hBF));
        check("single_res_y",    32'(res_y), 32'(8'h01));

        // Simultaneous held requests from reset: grants alternate 0,1,0,1.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; x0 = 8'd1; x1 = 8'd2; y0 = 8'd3; y1 = 8'd4;
        for (int i = 0; i < 50; i++) step();
        req0 = 1'b0; req1 = 1'b0;
        check("rr_gnt_count", 32'(gnt_order.size() >= 4), 32'(1));
        for (int i = 0; i < 4 && i < gnt_order.size(); i++)
            check("rr_order", 32'(gnt_order[i]), 32'(i % 2));
        check("rr_done_count", 32'(done_rx.size() >= 2), 32'(1));
        if (done_rx.size() >= 2) begin
            check("rr_done0_x", 32'(done_rx[0]), 32'(8'hFE));
            check("rr_done1_x", 32'(done_rx[1]), 32'(8'hFD));
        end

        // Back-to-back requester 1, operand stepping on each grant.
        do_reset();
        req1 = 1'b1; x1 = 8'd10;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gnt1) begin
                g1.push_back(cyc);
                if (g1.size() == 3) req1 = 1'b0;
                else x1 = x1 + 8'd1;
            end
        end
        check("b2b_gnt_count", 32'(g1.size()), 32'(3));
        if (g1.size() == 3) begin
            check("b2b_space1", 32'(g1[1] - g1[0]), 32'(12));
            check("b2b_space2", 32'(g1[2] - g1[1]), 32'(12));
        end
        check("b2b_done_count", 32'(done_rx.size()), 32'(3));
        if (done_rx.size() == 3) begin
            check("b2b_res0", 32'(done_rx[0]), 32'(8'hF5));
            check("b2b_res1", 32'(done_rx[1]), 32'(8'hF4));
            check("b2b_res2", 32'(done_rx[2]), 32'(8'hF3));
        end

        // Reset in C6 of an operation drops it; a later request completes.
        do_reset();
        req0 = 1'b1; x0 = 8'd7;
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gnt0) req0 = 1'b0;
        end
        rst = 1'b1;
        d = done_n;
        step();
        rst = 1'b0;
        check("rst_start", 32'(core_bus.Start_Pulse), 32'(0));
        check("rst_busy",  32'(busy), 32'(0));
        for (int i = 0; i < 12; i++) step();
        check("rst_no_done", 32'(done_n), 32'(d));
        req0 = 1'b1; x0 = 8'd33;
        for (int i = 0; i < 14; i++) begin
            step();
            if (gnt0) req0 = 1'b0;
        end
        check("rst_after_done", 32'(done_n), 32'(d + 1));
        check("rst_after_res",  32'(res_x), 32'(8'hDE));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit s0, s1;
            step();
            s0 = gnt0;
            s1 = gnt1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            drive_req(s0, req0, the0, x0, y0);
            drive_req(s1, req1, the1, x1, y1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
